// File: rtl/dom_share_feeder.sv
// Input-sharing / randomness stage feeding a two-share DOM-independent AND gadget.
// Define DOM_SHARE_FEEDER_ZERO_RAND_EN to force all masks to zero (unmasked baseline).
module dom_share_feeder #(
  parameter int          W      = 1,
  parameter logic [31:0] SEED   = 32'hACE1_2468,
  parameter int          WARMUP = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         seed_valid,
  input  logic [31:0]  seed,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] a0,
  output logic [W-1:0] a1,
  output logic [W-1:0] b0,
  output logic [W-1:0] b1,
  output logic [W-1:0] z,
  output logic         running,
  output logic [15:0]  tx_count
);

  typedef enum logic [0:0] {
    ST_WARMUP = 1'b0,
    ST_RUN    = 1'b1
  } state_e;

  localparam logic [7:0] WARM_LAST = 8'(WARMUP - 1);

  // Galois step for x^32+x^22+x^2+x+1; a nonzero state never maps to zero.
  function automatic logic [31:0] lfsr_step(input logic [31:0] v);
    return (v >> 1) ^ (v[0] ? 32'h8020_0003 : 32'h0000_0000);
  endfunction

  state_e        state_q, state_d;
  logic [7:0]    warm_cnt_q, warm_cnt_d;
  logic [31:0]   lfsr_q, lfsr_d;
  logic          out_valid_q, out_valid_d;
  logic          running_q, running_d;
  logic [15:0]   tx_count_q, tx_count_d;
  logic [W-1:0]  a0_q, a0_d, a1_q, a1_d, b0_q, b0_d, b1_q, b1_d, z_q, z_d;
  logic [W-1:0]  ra, rb, rz;
  logic          accept;

`ifdef DOM_SHARE_FEEDER_ZERO_RAND_EN
  assign ra = {W{1'b0}};
  assign rb = {W{1'b0}};
  assign rz = {W{1'b0}};
`else
  assign ra = lfsr_q[W-1:0];
  assign rb = lfsr_q[2*W-1:W];
  assign rz = lfsr_q[3*W-1:2*W];
`endif

  // A reseed in the same cycle always blocks the input.
  assign in_ready = running_q && !seed_valid && (!out_valid_q || out_ready);
  assign accept   = in_valid && in_ready;

  // Next-state logic: output register, transaction counter, LFSR and warm-up FSM.
  always_comb begin
    state_d     = state_q;
    warm_cnt_d  = warm_cnt_q;
    lfsr_d      = lfsr_q;
    out_valid_d = out_valid_q;
    tx_count_d  = tx_count_q;
    a0_d        = a0_q;
    a1_d        = a1_q;
    b0_d        = b0_q;
    b1_d        = b1_q;
    z_d         = z_q;

    if (accept) begin
      a0_d        = a ^ ra;
      a1_d        = ra;
      b0_d        = b ^ rb;
      b1_d        = rb;
      z_d         = rz;
      out_valid_d = 1'b1;
      tx_count_d  = tx_count_q + 16'd1;
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end else begin
      out_valid_d = out_valid_q;
    end

    // A pending output survives a reseed and drains through the logic above.
    if (seed_valid) begin
      lfsr_d     = (seed == 32'h0000_0000) ? SEED : seed;
      warm_cnt_d = 8'd0;
      state_d    = ST_WARMUP;
    end else begin
      case (state_q)
        ST_WARMUP: begin
          lfsr_d = lfsr_step(lfsr_q);
          if (warm_cnt_q == WARM_LAST) begin
            state_d    = ST_RUN;
            warm_cnt_d = 8'd0;
          end else begin
            warm_cnt_d = warm_cnt_q + 8'd1;
          end
        end
        ST_RUN: begin
          if (accept) begin
            lfsr_d = lfsr_step(lfsr_q);
          end else begin
            lfsr_d = lfsr_q;
          end
        end
        default: begin
          state_d    = ST_WARMUP;
          warm_cnt_d = 8'd0;
        end
      endcase
    end

    running_d = (state_d == ST_RUN);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_WARMUP;
      warm_cnt_q  <= 8'd0;
      lfsr_q      <= SEED;
      out_valid_q <= 1'b0;
      running_q   <= 1'b0;
      tx_count_q  <= 16'd0;
      a0_q        <= {W{1'b0}};
      a1_q        <= {W{1'b0}};
      b0_q        <= {W{1'b0}};
      b1_q        <= {W{1'b0}};
      z_q         <= {W{1'b0}};
    end else begin
      state_q     <= state_d;
      warm_cnt_q  <= warm_cnt_d;
      lfsr_q      <= lfsr_d;
      out_valid_q <= out_valid_d;
      running_q   <= running_d;
      tx_count_q  <= tx_count_d;
      a0_q        <= a0_d;
      a1_q        <= a1_d;
      b0_q        <= b0_d;
      b1_q        <= b1_d;
      z_q         <= z_d;
    end
  end

  assign out_valid = out_valid_q;
  assign running   = running_q;
  assign tx_count  = tx_count_q;
  assign a0        = a0_q;
  assign a1        = a1_q;
  assign b0        = b0_q;
  assign b1        = b1_q;
  assign z         = z_q;

endmodule

// File: tb/tb_dom_share_feeder.sv
// Randomized self-checking bench for dom_share_feeder against a behavioural model.
// Honours DOM_SHARE_FEEDER_ZERO_RAND_EN when the design is built with it.
module tb_dom_share_feeder;

  localparam int          W      = 3;
  localparam int          WARMUP = 32;
  localparam logic [31:0] SEED   = 32'hACE1_2468;

  logic         clk = 1'b0;
  logic         rst, seed_valid, in_valid, out_ready;
  logic [31:0]  seed;
  logic [W-1:0] a, b;
  logic         in_ready, out_valid, running;
  logic [W-1:0] a0, a1, b0, b1, z;
  logic [15:0]  tx_count;

  always #5 clk = ~clk;

  dom_share_feeder #(.W(W), .SEED(SEED), .WARMUP(WARMUP)) dut (
    .clk(clk), .rst(rst), .seed_valid(seed_valid), .seed(seed),
    .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
    .out_valid(out_valid), .out_ready(out_ready),
    .a0(a0), .a1(a1), .b0(b0), .b1(b1), .z(z),
    .running(running), .tx_count(tx_count)
  );

  int errors = 0;
  int checks = 0;

  // Model: the LFSR as a number, warm-up as "cycles since seed", one output slot.
  logic [31:0]  m_lfsr;
  int           m_since;
  bit           m_ov;
  logic [W-1:0] m_a0, m_a1, m_b0, m_b1, m_z, m_a, m_b;
  logic [15:0]  m_tx;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] m_step(input logic [31:0] v);
    return (v >> 1) ^ (v[0] ? 32'h8020_0003 : 32'h0000_0000);
  endfunction

  task automatic m_reset();
    m_lfsr = SEED; m_since = 0; m_ov = 1'b0; m_tx = 16'd0;
    m_a0 = '0; m_a1 = '0; m_b0 = '0; m_b1 = '0; m_z = '0; m_a = '0; m_b = '0;
  endtask

  // One clock: drive at negedge, check in_ready, advance model, check outputs next negedge.
  task automatic cyc(input bit r, input bit sv, input logic [31:0] sd, input bit iv,
                     input logic [W-1:0] av, input logic [W-1:0] bv, input bit ordy);
    bit m_run, exp_rdy, acc;
    logic [W-1:0] ra, rb, rz;
    rst = r; seed_valid = sv; seed = sd; in_valid = iv; a = av; b = bv; out_ready = ordy;
    #1;
    m_run   = (m_since >= WARMUP);
    exp_rdy = m_run && !sv && (!m_ov || ordy);
    chk("in_ready", 32'(in_ready), 32'(exp_rdy));
    if (r) begin
      m_reset();
    end else begin
      acc = iv && exp_rdy;
`ifdef DOM_SHARE_FEEDER_ZERO_RAND_EN
      ra = '0; rb = '0; rz = '0;
`else
      ra = W'(m_lfsr);
      rb = W'(m_lfsr >> W);
      rz = W'(m_lfsr >> (2 * W));
`endif
      if (acc) begin
        m_a0 = av ^ ra; m_a1 = ra; m_b0 = bv ^ rb; m_b1 = rb; m_z = rz;
        m_a = av; m_b = bv; m_ov = 1'b1; m_tx = m_tx + 16'd1;
      end else if (m_ov && ordy) begin
        m_ov = 1'b0;
      end
      if (sv) begin
        m_lfsr  = (sd == 32'd0) ? SEED : sd;
        m_since = 0;
      end else begin
        if (!m_run || acc) m_lfsr = m_step(m_lfsr);
        if (m_since < WARMUP) m_since++;
      end
    end
    @(posedge clk);
    @(negedge clk);
    chk("out_valid", 32'(out_valid), 32'(m_ov));
    chk("running", 32'(running), 32'(m_since >= WARMUP));
    chk("tx_count", 32'(tx_count), 32'(m_tx));
    if (m_ov) begin
      chk("a0", 32'(a0), 32'(m_a0));
      chk("a1", 32'(a1), 32'(m_a1));
      chk("b0", 32'(b0), 32'(m_b0));
      chk("b1", 32'(b1), 32'(m_b1));
      chk("z", 32'(z), 32'(m_z));
      chk("inv_a", 32'(a0 ^ a1), 32'(m_a));
      chk("inv_b", 32'(b0 ^ b1), 32'(m_b));
    end
  endtask

  task automatic idle(input int n, input bit ordy);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 32'd0, 1'b0, '0, '0, ordy);
  endtask

  initial begin
    rst = 1'b1; seed_valid = 1'b0; seed = 32'd0; in_valid = 1'b0;
    a = '0; b = '0; out_ready = 1'b0;
    m_reset();
    @(negedge clk);

    // Reset state, then the warm-up window with inputs offered.
    cyc(1'b1, 1'b0, 32'd0, 1'b1, 3'd5, 3'd2, 1'b1);
    chk("rst_a0", 32'(a0), 32'd0);
    chk("rst_z", 32'(z), 32'd0);
    chk("rst_running", 32'(running), 32'd0);
    chk("rst_tx", 32'(tx_count), 32'd0);
    for (int i = 1; i <= 40; i++) begin
      cyc(1'b0, 1'b0, 32'd0, 1'b1, 3'($urandom), 3'($urandom), 1'b1);
      if (i == WARMUP - 1) chk("run_c31", 32'(running), 32'd0);
      if (i == WARMUP)     chk("run_c32", 32'(running), 32'd1);
    end

    // Fresh start, then 100 back-to-back accepts.
    cyc(1'b1, 1'b0, 32'd0, 1'b0, '0, '0, 1'b1);
    idle(WARMUP, 1'b1);
    for (int i = 0; i < 100; i++) cyc(1'b0, 1'b0, 32'd0, 1'b1, 3'($urandom), 3'($urandom), 1'b1);
    chk("tx_100", 32'(tx_count), 32'd100);

    // Back-pressure freezes shares and blocks input.
    for (int i = 0; i < 5; i++) begin
      cyc(1'b0, 1'b0, 32'd0, 1'b1, 3'($urandom), 3'($urandom), 1'b0);
      chk("bp_in_ready", 32'(in_ready), 32'd0);
    end

    // Zero reseed colliding with an input while an output is pending.
    cyc(1'b0, 1'b1, 32'd0, 1'b1, 3'd7, 3'd7, 1'b0);
    chk("reseed_hold_ov", 32'(out_valid), 32'd1);
    chk("reseed_tx", 32'(tx_count), 32'd100);
    cyc(1'b0, 1'b0, 32'd0, 1'b0, '0, '0, 1'b1);
    chk("reseed_drain", 32'(out_valid), 32'd0);
    idle(WARMUP + 2, 1'b1);

    // Known operands (a=1,b=1) then reset under back-pressure.
    cyc(1'b0, 1'b0, 32'd0, 1'b1, 3'd1, 3'd1, 1'b1);
    chk("k_inv_a", 32'(a0 ^ a1), 32'd1);
    cyc(1'b0, 1'b0, 32'd0, 1'b0, '0, '0, 1'b0);
    cyc(1'b1, 1'b0, 32'd0, 1'b0, '0, '0, 1'b0);
    chk("mid_rst_ov", 32'(out_valid), 32'd0);
    chk("mid_rst_a1", 32'(a1), 32'd0);
    chk("mid_rst_b0", 32'(b0), 32'd0);
    chk("mid_rst_tx", 32'(tx_count), 32'd0);

    // Random traffic with occasional reseeds and resets.
    for (int i = 0; i < 1500; i++) begin
      cyc(($urandom_range(0, 299) == 0),
          ($urandom_range(0, 59) == 0),
          ($urandom_range(0, 2) == 0) ? 32'd0 : 32'($urandom),
          ($urandom_range(0, 3) != 0),
          3'($urandom), 3'($urandom),
          ($urandom_range(0, 3) != 0));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dom_share_feeder.md
# dom_share_feeder

Input-sharing and randomness stage placed directly upstream of the two-share DOM-independent AND gadget. It takes unmasked operands `a` and `b`, splits each into two Boolean shares using masks from an internal 32-bit LFSR, and supplies the fresh refresh randomness `z` that the gadget consumes. All outputs come from a single registered stage with a valid/ready handshake. An LFSR warm-up state machine guarantees that no sharing is produced from a freshly loaded seed.

## Interface
Parameters:
- `W`, 1: operand width in bits; legal range 1..10, since 3*W ≤ 32.
- `SEED`, 32'hACE1_2468: LFSR reset seed. Also substituted whenever a zero seed is loaded.
- `WARMUP`, 32: number of LFSR steps between seed load and the first accepted input; legal range 1..255.

Ports:
- `clk`, input, 1: clock, rising edge.
- `rst`, input, 1: synchronous, active-high reset.
- `seed_valid`, input, 1: load `seed` into the LFSR this cycle.
- `seed`, input, 32: new LFSR seed.
- `in_valid`, input, 1: `a`/`b` valid.
- `in_ready`, output, 1: stage can accept an input this cycle.
- `a`, input, W: unmasked operand A.
- `b`, input, W: unmasked operand B.
- `out_valid`, output, 1: share outputs valid.
- `out_ready`, input, 1: downstream accepts the shares.
- `a0`, `a1`, output, W: shares of A.
- `b0`, `b1`, output, W: shares of B.
- `z`, output, W: fresh refresh randomness for the AND gadget.
- `running`, output, 1: high in RUN state.
- `tx_count`, output, 16: count of accepted inputs; wraps modulo 2^16.

## Operation
- LFSR: 32-bit Galois, polynomial x^32+x^22+x^2+x+1.
  - Step rule: `lfsr <= (lfsr >> 1) ^ (lfsr[0] ? 32'h8020_0003 : 0)`.
  - The LFSR never holds zero.
- Random slices taken from the current (pre-step) LFSR value:
  - `ra = lfsr[W-1:0]`
  - `rb = lfsr[2W-1:W]`
  - `rz = lfsr[3W-1:2W]`
- On accept (`in_valid && in_ready`), the output register loads:
  - `a0 = a ^ ra`, `a1 = ra`
  - `b0 = b ^ rb`, `b1 = rb`
  - `z = rz`
  - `out_valid` is set, `tx_count` increments, and the LFSR steps on the same edge.
- Invariants: `a0 ^ a1 == a` and `b0 ^ b1 == b` at every cycle where `out_valid` is high.
- FSM states:
  - WARMUP: LFSR steps every cycle and `warm_cnt` increments. When `warm_cnt == WARMUP-1`, transition to RUN.
  - RUN: LFSR steps only on accept.
- `in_ready = running && !seed_valid && (!out_valid || out_ready)`.
- Output register:
  - Cleared (`out_valid` drops) when `out_valid && out_ready` and no new accept occurs.
  - Shares are held stable while `out_valid && !out_ready`.
- Reseed: `seed_valid` is accepted in any state.
  - LFSR loads `seed`, or `SEED` if `seed == 0`.
  - `warm_cnt` clears and the state goes to WARMUP.
  - A pending output is not discarded; it drains normally.
- Simultaneous `seed_valid` and `in_valid`: the reseed wins, the input is not accepted, and `in_ready` is 0.

## Timing
- Reset values:
  - `in_ready` = 0
  - `out_valid` = 0
  - `a0`, `a1`, `b0`, `b1`, `z` = 0
  - `running` = 0
  - `tx_count` = 0
  - state = WARMUP, `warm_cnt` = 0, LFSR = `SEED`
- `rst` mid-operation discards any pending output and returns every register to its reset value on that edge. `rst` has priority over `seed_valid`.
- `running` rises exactly WARMUP cycles after reset release, or after the reseed edge.
- Latency: shares are valid on the cycle after the accept edge.
- Throughput: 1 transaction per cycle while `out_ready` is held high.
- Back-pressure: with `out_ready` low and `out_valid` high, `in_ready` is low, and the outputs and the LFSR are frozen (except in WARMUP).
- `tx_count` wraps from 16'hFFFF to 16'h0000 without any side effect.

## Configuration
- `DOM_SHARE_FEEDER_ZERO_RAND_EN` defined:
  - `ra`, `rb` and `rz` are forced to 0, so `a1 = b1 = z = 0`, `a0 = a` and `b0 = b`.
  - The LFSR, FSM, handshake and `tx_count` behave identically.
  - Used as the unmasked baseline for leakage-check comparison.
- Not defined: masks are taken from the LFSR as specified in Operation.

## Test plan
- Reset release with `W=1`, `WARMUP=32`: `in_ready=0` and `running=0` for cycles 0..31; `running=1` on cycle 32; `out_valid=0` throughout.
- `W=1`, `a=1`, `b=0` accepted in RUN: next cycle `out_valid=1`, `a0^a1=1`, `b0^b1=0`, and `a1` equals bit 0 of the LFSR value at accept. Feeding the downstream DOM AND yields `c0^c1 = 0`.
- 100 back-to-back inputs with `out_ready=1` and `W=3`: one output per cycle, sharing invariants hold on every output, `tx_count=100`. Holding `out_ready=0` for 5 cycles freezes `a0..z` and deasserts `in_ready`.
- `seed_valid=1` with `seed=0` and `in_valid=1` on the same cycle: input not accepted, LFSR = 32'hACE1_2468, `running=0` for the next 32 cycles, pending output still drains.
- Synchronous `rst` asserted while `out_valid=1` and `out_ready=0`: next cycle all outputs are 0 and `tx_count=0`.
- Build with `DOM_SHARE_FEEDER_ZERO_RAND_EN`, `a=1`, `b=1`: `a0=1`, `a1=0`, `b0=1`, `b1=0`, `z=0`.
